// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: handshake and operand/result bundle for serial_subtractor.
//   start  - request, sampled only while the subtractor is idle
//   a, b   - minuend / subtrahend, captured when start is accepted
//   d      - result a - b (mod 256), held until the next completion
//   borrow - unsigned borrow (a < b)
//   yprx   - signed overflow (carry into bit 7 XOR carry out of bit 7)
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when d/borrow/yprx update
// master: the sequencing controller; slave: the subtractor.
interface serial_subtractor_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] d;
  logic       borrow;
  logic       yprx;
  logic       busy;
  logic       done;

  modport master (
    output start, a, b,
    input  d, borrow, yprx, busy, done
  );

  modport slave (
    input  start, a, b,
    output d, borrow, yprx, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial 8-bit two's-complement subtractor, d = a - b, computed LSB
// first as a + ~b + 1 through one registered full-adder slice. Eight processing cycles,
// then a one-cycle done pulse.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - serial_subtractor_if.slave (start/a/b in, d/borrow/yprx/busy/done out)
module serial_subtractor (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e     state_q;
  logic [7:0] sa_q;      // minuend, shifted right one bit per cycle
  logic [7:0] sb_q;      // subtrahend, shifted right one bit per cycle
  logic [7:0] sr_q;      // partial result, sum bits enter at bit 7
  logic       cy_q;      // carry into the bit currently being processed
  logic [2:0] cnt_q;     // index of the bit currently being processed
  logic [7:0] d_q;
  logic       borrow_q;
  logic       yprx_q;
  logic       busy_q;
  logic       done_q;

  // Full-adder slice on the current LSBs; subtrahend bit is inverted and the
  // carry is seeded with 1 at load time to form the two's complement.
  logic nb;
  logic s;
  logic c;

  always_comb begin
    nb = ~sb_q[0];
    s  = sa_q[0] ^ nb ^ cy_q;
    c  = (sa_q[0] & nb) | (sa_q[0] & cy_q) | (nb & cy_q);
  end

  // While bit 7 is processed, cy_q holds the carry into bit 7 and c the carry
  // out, so overflow is taken directly from them without a separate
  // previous-carry flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sa_q     <= 8'h00;
      sb_q     <= 8'h00;
      sr_q     <= 8'h00;
      cy_q     <= 1'b0;
      cnt_q    <= 3'd0;
      d_q      <= 8'h00;
      borrow_q <= 1'b0;
      yprx_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            cy_q    <= 1'b1;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          sr_q  <= {s, sr_q[7:1]};
          sa_q  <= {1'b0, sa_q[7:1]};
          sb_q  <= {1'b0, sb_q[7:1]};
          cy_q  <= c;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            d_q      <= {s, sr_q[7:1]};
            borrow_q <= ~c;
            yprx_q   <= cy_q ^ c;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StFin;
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.d      = d_q;
  assign bus.borrow = borrow_q;
  assign bus.yprx   = yprx_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed bench for serial_subtractor. Expected results are
// queued when an operation is launched and popped when done pulses.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_subtractor_if bus();

  serial_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       borrow;
    logic       yprx;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.d      = a - b;
    e.borrow = (a < b);
    e.yprx   = (a[7] != b[7]) && (e.d[7] != a[7]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: every done pulse must match the oldest outstanding launch.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        chk("busy_low_at_done", {31'b0, bus.busy}, 32'd0);
        chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("mon_d", {24'b0, bus.d}, {24'b0, mon_e.d});
          chk("mon_borrow", {31'b0, bus.borrow}, {31'b0, mon_e.borrow});
          chk("mon_yprx", {31'b0, bus.yprx}, {31'b0, mon_e.yprx});
        end
        done_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cyc.size() < target && k < budget) begin
      tick();
      k++;
    end
    chk("done_count", done_cyc.size(), target);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    int n0;
    n0 = done_cyc.size();
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    sb.push_back(model(a, b));
    tick();
    bus.start = 1'b0;
    wait_done(n0 + 1, 20);
  endtask

  initial begin
    int   n0;
    exp_t e;
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_d", {24'b0, bus.d}, 32'h0);
    chk("rst_borrow", {31'b0, bus.borrow}, 32'd0);
    chk("rst_yprx", {31'b0, bus.yprx}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 0x05 - 0x03 with cycle-exact handshake timing
    n0 = done_cyc.size();
    bus.a = 8'h05;
    bus.b = 8'h03;
    bus.start = 1'b1;
    sb.push_back(model(8'h05, 8'h03));
    tick();
    bus.start = 1'b0;
    chk("t1_busy_k", {31'b0, bus.busy}, 32'd1);
    chk("t1_done_k", {31'b0, bus.done}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t1_busy_run", {31'b0, bus.busy}, 32'd1);
      chk("t1_d_hidden", {24'b0, bus.d}, 32'h0);
    end
    tick();
    chk("t1_done_k8", {31'b0, bus.done}, 32'd1);
    chk("t1_busy_k8", {31'b0, bus.busy}, 32'd0);
    chk("t1_d", {24'b0, bus.d}, 32'h02);
    chk("t1_borrow", {31'b0, bus.borrow}, 32'd0);
    chk("t1_yprx", {31'b0, bus.yprx}, 32'd0);
    tick();
    chk("t1_done_k9", {31'b0, bus.done}, 32'd0);
    chk("t1_busy_k9", {31'b0, bus.busy}, 32'd0);
    chk("t1_one_done", done_cyc.size(), n0 + 1);

    run_op(8'h03, 8'h05);
    chk("t2_d", {24'b0, bus.d}, 32'hfe);
    chk("t2_borrow", {31'b0, bus.borrow}, 32'd1);
    run_op(8'h80, 8'h01);
    chk("t3_d", {24'b0, bus.d}, 32'h7f);
    chk("t3_yprx", {31'b0, bus.yprx}, 32'd1);
    run_op(8'h7f, 8'hff);
    chk("t4_d", {24'b0, bus.d}, 32'h80);
    chk("t4_borrow", {31'b0, bus.borrow}, 32'd1);
    chk("t4_yprx", {31'b0, bus.yprx}, 32'd1);

    // Abort mid-run: outputs must clear without waiting for a clock edge.
    bus.a = 8'h12;
    bus.b = 8'h34;
    bus.start = 1'b1;
    sb.push_back(model(8'h12, 8'h34));
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_d", {24'b0, bus.d}, 32'h0);
    chk("abort_borrow", {31'b0, bus.borrow}, 32'd0);
    chk("abort_yprx", {31'b0, bus.yprx}, 32'd0);
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(8'hff, 8'hff);
    e = model(8'hff, 8'hff);
    chk("t5_d", {24'b0, bus.d}, {24'b0, e.d});

    // Start pulses and operand changes during RUN/FIN are ignored.
    busy_cnt = 0;
    n0 = done_cyc.size();
    bus.a = 8'h10;
    bus.b = 8'h01;
    bus.start = 1'b1;
    sb.push_back(model(8'h10, 8'h01));
    tick();
    bus.start = 1'b0;
    tick();
    bus.a = 8'h55;
    bus.b = 8'h22;
    bus.start = 1'b1;
    repeat (8) tick();
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    repeat (3) tick();
    chk("ign_single_done", done_cyc.size(), n0 + 1);
    chk("ign_busy_cycles", busy_cnt, 8);
    chk("ign_d", {24'b0, bus.d}, 32'h0f);

    // start held high: three back-to-back accepts, ten cycles apart.
    n0 = done_cyc.size();
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.start = 1'b1;
    repeat (3) sb.push_back(model(8'h00, 8'h00));
    tick();
    repeat (20) tick();
    bus.start = 1'b0;
    wait_done(n0 + 3, 40);
    chk("hold_gap1", done_cyc[n0 + 1] - done_cyc[n0], 10);
    chk("hold_gap2", done_cyc[n0 + 2] - done_cyc[n0 + 1], 10);

    repeat (12) tick();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
